// File: rtl/uart_servo_array.sv
// uart_servo_array
//   Multi-channel servo controller driven over an 8N1 UART. A host sends
//   3-byte commands {SYNC_BYTE, channel, position}. Each accepted command
//   updates that channel's target. Once per PWM frame, every channel's
//   position moves toward its target by at most SLEW_STEP. All channels
//   share one frame counter, and each drives a pulse of width
//   MIN_PULSE + position * PULSE_STEP clocks.
//
// Ports
//   clk50mhz       in   system clock
//   rst            in   asynchronous, active-high reset
//   uart_rx        in   asynchronous UART line, idle high
//   servo_pwm_out  out  [NUM_CH] registered PWM, bit i = channel i
//   cmd_valid      out  one-cycle pulse when a command updates a target
//   cmd_ch         out  [4] channel of the last accepted command (held)
//   frame_err      out  one-cycle pulse on a bad stop bit or an out-of-range channel
module uart_servo_array #(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         BAUD_RATE  = 9600,
    parameter int         NUM_CH     = 4,
    parameter int         PERIOD_CYC = 1000000,
    parameter int         MIN_PULSE  = 50000,
    parameter int         PULSE_STEP = 392,
    parameter int         SLEW_STEP  = 1,
    parameter logic [7:0] SYNC_BYTE  = 8'hFF,
    parameter int         INVERT     = 1
) (
    input  logic              clk50mhz,
    input  logic              rst,
    input  logic              uart_rx,
    output logic [NUM_CH-1:0] servo_pwm_out,
    output logic              cmd_valid,
    output logic [3:0]        cmd_ch,
    output logic              frame_err
);

    localparam int                BAUD_TICK   = CLK_FREQ / BAUD_RATE;
    localparam logic [31:0]       HALF_LOAD   = 32'(BAUD_TICK / 2 - 1);
    localparam logic [31:0]       FULL_LOAD   = 32'(BAUD_TICK - 1);
    localparam logic [31:0]       PERIOD_LAST = 32'(PERIOD_CYC - 1);
    localparam logic [7:0]        NUM_CH_B    = 8'(NUM_CH);
    localparam logic [7:0]        STEP_B      = 8'(SLEW_STEP);
    localparam logic signed [9:0] STEP_S      = 10'(SLEW_STEP);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;
    typedef enum logic [1:0] {P_IDLE, P_CH, P_POS} pars_st_t;

    // Move pos toward tgt by at most SLEW_STEP. Signed 10-bit difference so
    // the result can neither overshoot nor wrap through 0/255.
    function automatic logic [7:0] slew_next(input logic [7:0] pos, input logic [7:0] tgt);
        logic signed [9:0] d;
        d = $signed({2'b00, tgt}) - $signed({2'b00, pos});
        if (d > STEP_S)
            slew_next = pos + STEP_B;
        else if (d < -STEP_S)
            slew_next = pos - STEP_B;
        else
            slew_next = tgt;
    endfunction

    // 32-bit unsigned arithmetic, enough for MIN_PULSE + 255 * PULSE_STEP.
    function automatic logic [31:0] pulse_width(input logic [7:0] pos);
        pulse_width = 32'(MIN_PULSE) + 32'(pos) * 32'(PULSE_STEP);
    endfunction

    // ---------------- state ----------------
    logic             rx_meta_q, rx_sync_q;
    uart_st_t         ust_q, ust_d;
    logic [31:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    pars_st_t         pst_q, pst_d;
    logic [3:0]       ch_q, ch_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [3:0]       cmd_ch_q, cmd_ch_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       tgt_q [NUM_CH];
    logic [7:0]       pos_q [NUM_CH];
    logic [31:0]      pwm_cnt_q, pwm_cnt_d;
    logic [NUM_CH-1:0] pwm_q;

    logic             byte_stb, stop_err, tgt_we;
    logic [7:0]       tgt_val;

    // ---------------- stage: UART bit receiver ----------------
    always_comb begin
        ust_d    = ust_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        byte_stb = 1'b0;
        stop_err = 1'b0;
        case (ust_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    ust_d  = START;
                    baud_d = HALF_LOAD;
                end
            end
            START: begin
                if (baud_q == 32'd0) begin
                    if (rx_sync_q) begin
                        ust_d = IDLE;            // too short to be a start bit
                    end else begin
                        ust_d  = DATA;
                        baud_d = FULL_LOAD;
                        bit_d  = 3'd0;
                    end
                end else begin
                    baud_d = baud_q - 32'd1;
                end
            end
            DATA: begin
                if (baud_q == 32'd0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    baud_d  = FULL_LOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        ust_d = STOP;
                end else begin
                    baud_d = baud_q - 32'd1;
                end
            end
            STOP: begin
                if (baud_q == 32'd0) begin
                    byte_stb = rx_sync_q;
                    stop_err = !rx_sync_q;
                    ust_d    = IDLE;
                end else begin
                    baud_d = baud_q - 32'd1;
                end
            end
            default: ust_d = IDLE;
        endcase
    end

    // ---------------- stage: command parser ----------------
    assign tgt_val = (INVERT != 0) ? ~shift_q : shift_q;

    always_comb begin
        pst_d       = pst_q;
        ch_d        = ch_q;
        cmd_valid_d = 1'b0;
        cmd_ch_d    = cmd_ch_q;
        frame_err_d = 1'b0;
        tgt_we      = 1'b0;
        if (stop_err) begin
            frame_err_d = 1'b1;
            pst_d       = P_IDLE;
        end else if (byte_stb) begin
            case (pst_q)
                P_IDLE: begin
                    if (shift_q == SYNC_BYTE)
                        pst_d = P_CH;
                end
                P_CH: begin
                    if (shift_q == SYNC_BYTE) begin
                        pst_d = P_CH;
                    end else if (shift_q < NUM_CH_B) begin
                        ch_d  = shift_q[3:0];
                        pst_d = P_POS;
                    end else begin
                        frame_err_d = 1'b1;
                        pst_d       = P_IDLE;
                    end
                end
                P_POS: begin
                    if (shift_q == SYNC_BYTE) begin
                        pst_d = P_CH;
                    end else begin
                        tgt_we      = 1'b1;
                        cmd_valid_d = 1'b1;
                        cmd_ch_d    = ch_q;
                        pst_d       = P_IDLE;
                    end
                end
                default: pst_d = P_IDLE;
            endcase
        end
    end

    // ---------------- stage: frame counter ----------------
    assign pwm_cnt_d = (pwm_cnt_q == PERIOD_LAST) ? 32'd0 : pwm_cnt_q + 32'd1;

    always_ff @(posedge clk50mhz or posedge rst) begin
        if (rst) begin
            // Synchroniser resets to the idle level so reset never looks like a start bit.
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            ust_q       <= IDLE;
            baud_q      <= 32'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            pst_q       <= P_IDLE;
            ch_q        <= 4'd0;
            cmd_valid_q <= 1'b0;
            cmd_ch_q    <= 4'd0;
            frame_err_q <= 1'b0;
            pwm_cnt_q   <= 32'd0;
            pwm_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= 8'd128;
                pos_q[i] <= 8'd128;
            end
        end else begin
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            ust_q       <= ust_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            pst_q       <= pst_d;
            ch_q        <= ch_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_ch_q    <= cmd_ch_d;
            frame_err_q <= frame_err_d;
            pwm_cnt_q   <= pwm_cnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (tgt_we && (ch_q == 4'(i)))
                    tgt_q[i] <= tgt_val;
                // Slew reads the pre-write target, so a same-cycle write lands next frame.
                if (pwm_cnt_q == 32'd0)
                    pos_q[i] <= slew_next(pos_q[i], tgt_q[i]);
                pwm_q[i] <= (pwm_cnt_q < pulse_width(pos_q[i]));
            end
        end
    end

    assign servo_pwm_out = pwm_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_ch        = cmd_ch_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_servo_array.sv
module tb_uart_servo_array;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx  = 1'b1;
    logic [NCH-1:0] pwm_a, pwm_b;
    logic           val_a, val_b, err_a, err_b;
    logic [3:0]     ch_a, ch_b;

    int checks   = 0;
    int failures = 0;
    int n_val    = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Slow-slew instance and a fast-slew instance that jumps straight to target;
    // both listen to the same line.
    uart_servo_array #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .NUM_CH(NCH), .PERIOD_CYC(2000),
        .MIN_PULSE(100), .PULSE_STEP(4), .SLEW_STEP(1), .SYNC_BYTE(8'hFF), .INVERT(1)
    ) dut_a (
        .clk50mhz(clk), .rst(rst), .uart_rx(rx), .servo_pwm_out(pwm_a),
        .cmd_valid(val_a), .cmd_ch(ch_a), .frame_err(err_a)
    );

    uart_servo_array #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .NUM_CH(NCH), .PERIOD_CYC(2000),
        .MIN_PULSE(100), .PULSE_STEP(4), .SLEW_STEP(255), .SYNC_BYTE(8'hFF), .INVERT(1)
    ) dut_b (
        .clk50mhz(clk), .rst(rst), .uart_rx(rx), .servo_pwm_out(pwm_b),
        .cmd_valid(val_b), .cmd_ch(ch_b), .frame_err(err_b)
    );

    always @(negedge clk) begin
        if (val_a) n_val++;
        if (err_a) n_err++;
    end

    typedef struct {
        logic [3:0][7:0] b;
        int              nb;
        int              bad;   // index of the byte sent with a 0 stop bit, -1 for none
        int              ev;    // cmd_valid pulses expected
        int              ee;    // frame_err pulses expected
        int              ech;   // cmd_ch expected afterwards
    } vec_t;

    vec_t vt [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit bad);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (10) @(negedge clk);
        end
        rx = bad ? 1'b0 : 1'b1;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    function automatic logic getbit(input int which, input int ch);
        logic [1:0] c;
        c = ch[1:0];
        if (which == 0) return pwm_a[c];
        return pwm_b[c];
    endfunction

    // High time of the next complete pulse; -1 if the output never toggles.
    task automatic measure(input int which, input int ch, output int w);
        int guard;
        w = -1;
        guard = 0;
        while (getbit(which, ch) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) return;
        guard = 0;
        while (!getbit(which, ch) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) return;
        w = 0;
        while (getbit(which, ch) && w < 3000) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic apply_vec(input int k);
        int v0, e0;
        v0 = n_val;
        e0 = n_err;
        for (int j = 0; j < vt[k].nb; j++)
            send_byte(vt[k].b[j], (j == vt[k].bad));
        repeat (30) @(negedge clk);
        check($sformatf("vec%0d_valid", k), n_val - v0, vt[k].ev);
        check($sformatf("vec%0d_err", k), n_err - e0, vt[k].ee);
        check($sformatf("vec%0d_ch", k), int'(ch_a), vt[k].ech);
    endtask

    initial begin
        int w, w1, w2, v0, e0;

        // FF 02 28 -> ch2 target 255-0x28 = 215
        vt[0].b = '{8'h00, 8'h28, 8'h02, 8'hFF}; vt[0].nb = 3; vt[0].bad = -1;
        vt[0].ev = 1; vt[0].ee = 0; vt[0].ech = 2;
        // FF 07 10 -> channel out of range, trailing 10 ignored
        vt[1].b = '{8'h00, 8'h10, 8'h07, 8'hFF}; vt[1].nb = 3; vt[1].bad = -1;
        vt[1].ev = 0; vt[1].ee = 1; vt[1].ech = 2;
        // FF 01 00 -> ch1 target 255
        vt[2].b = '{8'h00, 8'h00, 8'h01, 8'hFF}; vt[2].nb = 3; vt[2].bad = -1;
        vt[2].ev = 1; vt[2].ee = 0; vt[2].ech = 1;
        // FF 00(bad stop) 10 -> error, parser idle, 10 ignored
        vt[3].b = '{8'h00, 8'h10, 8'h00, 8'hFF}; vt[3].nb = 3; vt[3].bad = 1;
        vt[3].ev = 0; vt[3].ee = 1; vt[3].ech = 1;
        // FF FF 03 80 -> resync, ch3 target 127
        vt[4].b = '{8'h80, 8'h03, 8'hFF, 8'hFF}; vt[4].nb = 4; vt[4].bad = -1;
        vt[4].ev = 1; vt[4].ee = 0; vt[4].ech = 3;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pwm_a", int'(pwm_a), 0);
        check("rst_pwm_b", int'(pwm_b), 0);
        check("rst_cmd_valid", int'(val_a), 0);
        check("rst_cmd_ch", int'(ch_a), 0);
        check("rst_frame_err", int'(err_a), 0);
        rst = 1'b0;

        for (int c = 0; c < NCH; c++) begin
            measure(0, c, w);
            check($sformatf("init_width_ch%0d", c), w, 612);
        end

        for (int k = 0; k < 4; k++)
            apply_vec(k);

        // 3-clock low glitch: no byte, no error
        v0 = n_val;
        e0 = n_err;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid", n_val - v0, 0);
        check("glitch_err", n_err - e0, 0);

        apply_vec(4);

        // Slow slew: ch2 climbs 4 clocks per frame toward 960
        measure(0, 2, w1);
        measure(0, 2, w2);
        check("slew_a_ch2_moving", (w1 > 612 && w1 < 960) ? 1 : 0, 1);
        check("slew_a_ch2_step", w2 - w1, 4);
        measure(0, 0, w);
        check("slew_a_ch0_unchanged", w, 612);

        // Fast slew: every channel already at its target
        measure(1, 0, w);
        check("fast_b_ch0", w, 612);
        measure(1, 1, w);
        check("fast_b_ch1", w, 1120);
        measure(1, 2, w);
        check("fast_b_ch2", w, 960);
        measure(1, 3, w);
        check("fast_b_ch3", w, 608);

        // Reset in the middle of a byte, while all PWM outputs are high
        measure(0, 0, w);
        w = 0;
        while (!pwm_a[0] && w < 3000) begin
            @(negedge clk);
            w++;
        end
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("pre_rst_pwm_a", int'(pwm_a), 15);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm_a", int'(pwm_a), 0);
        check("async_rst_pwm_b", int'(pwm_b), 0);
        @(negedge clk);
        rst = 1'b0;
        v0 = n_val;
        e0 = n_err;
        measure(0, 2, w);
        check("post_rst_a_ch2", w, 612);
        measure(1, 1, w);
        check("post_rst_b_ch1", w, 612);
        check("post_rst_valid", n_val - v0, 0);
        check("post_rst_err", n_err - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_servo_array.md
Name: uart_servo_array

Overview:
- Multi-channel successor to the single-servo UART controller.
- Receives framed 3-byte commands over a parametrised 8N1 UART and updates per-channel servo targets.
- Slews each channel's position toward its target once per PWM frame.
- Drives NUM_CH independent 1–2 ms-class PWM outputs sharing one frame counter; sits between the host USB-UART pin and the servo headers.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD_RATE, 9600, UART bit rate; BAUD_TICK = CLK_FREQ/BAUD_RATE, integer divide.
- NUM_CH, 4, servo channel count, 1..16.
- PERIOD_CYC, 1000000, PWM frame length in clocks (20 ms at 50 MHz).
- MIN_PULSE, 50000, pulse width in clocks at position 0.
- PULSE_STEP, 392, clocks added per position LSB.
- SLEW_STEP, 1, maximum position change per frame, 1..255.
- SYNC_BYTE, 8'hFF, frame start marker.
- INVERT, 1, if 1 the stored target is 255 - data, else data.

Ports:
- clk50mhz  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  asynchronous UART line, idle high.
- servo_pwm_out  output  NUM_CH  registered PWM, bit i = channel i.
- cmd_valid  output  1  one-cycle pulse when a command is accepted.
- cmd_ch  output  4  channel of last accepted command; held between commands.
- frame_err  output  1  one-cycle pulse on a UART stop-bit error or an out-of-range channel.

Behaviour:
- Reset: one clock, asynchronous, active-high; all state clears asynchronously.
  - servo_pwm_out=0, cmd_valid=0, cmd_ch=0, frame_err=0.
  - All targets and positions = 128; PWM counter = 0; UART and parser FSMs = IDLE.
- RX sync: uart_rx passes through a 2-flop synchroniser; all UART logic uses the synchronised bit.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synchronised rx=0, go to START with the baud counter loaded to BAUD_TICK/2 - 1.
  - START: when the counter expires, sample the line.
    - rx=1 is a glitch; return to IDLE with no error.
    - rx=0: go to DATA, counter = BAUD_TICK - 1.
  - DATA: sample 8 bits LSB first, one every BAUD_TICK clocks, then go to STOP.
  - STOP: sample at bit centre.
    - rx=1 → one-cycle byte strobe with the data.
    - rx=0 → frame_err pulse; byte discarded; parser forced to IDLE.
    - Either way return to IDLE.
- Parser FSM states: P_IDLE, P_CH, P_POS.
  - P_IDLE: SYNC_BYTE → P_CH; any other byte is ignored.
  - P_CH:
    - SYNC_BYTE → stay in P_CH (resync).
    - Value < NUM_CH → latch channel, go to P_POS.
    - Otherwise → frame_err pulse, go to P_IDLE.
  - P_POS:
    - SYNC_BYTE → P_CH, with no update.
    - Otherwise:
      - target[ch] <= INVERT ? 255-byte : byte;
      - cmd_valid pulses in the same cycle as the target write;
      - cmd_ch <= ch;
      - go to P_IDLE.
    - Position value 255 is therefore unreachable when INVERT=0 and value 0 is unreachable when INVERT=1; this is by design.
- PWM counter: counts 0..PERIOD_CYC-1, then wraps to 0.
- Slew: applied in the cycle where counter==0, for every channel.
  - d = target - position.
  - If |d| <= SLEW_STEP, position <= target.
  - Else position moves SLEW_STEP toward target; never overshoots and never wraps past 0 or 255.
  - A target written in the same cycle as counter==0 is seen on the next frame.
- Pulse: width_i = MIN_PULSE + position_i * PULSE_STEP.
  - Arithmetic is unsigned and wide enough for MIN_PULSE + 255*PULSE_STEP without overflow; at defaults the maximum is 149960 < PERIOD_CYC.
  - servo_pwm_out[i] <= (counter < width_i), registered, i.e. one cycle behind the counter.
  - Frame 0 after reset gives width 100176 clocks per channel (position 128).
- Simultaneous events: a UART byte strobe, a slew update and a PWM compare in one cycle are independent, with no stall or priority.
- Reset during reception: the partial byte and partial frame are discarded.

Test Plan:
- Bench parameters: CLK_FREQ=1000000, BAUD_RATE=100000 (BAUD_TICK=10), PERIOD_CYC=2000, MIN_PULSE=100, PULSE_STEP=4, NUM_CH=4, SLEW_STEP=1, INVERT=1.
- Reset release: each servo_pwm_out bit goes high for 612 clocks (100+128*4) per 2000-clock frame. cmd_valid=0, frame_err=0.
- Send FF 02 28: cmd_valid pulses once and cmd_ch=2. target[2]=215; channel 2 width grows by 4 clocks per frame and reaches 960 after 87 frames. Other channels stay at 612.
- Send FF 07 10 (channel out of range): frame_err pulses once; no target changes; a following FF 01 00 is accepted (target[1]=255).
- Stop bit driven 0 on the channel byte of FF 00 <bad> 10: frame_err pulses; target[0] unchanged; the subsequent 10 is ignored until the next FF.
- rx low pulse of 3 clocks: no byte strobe and no error. Then send FF FF 03 80: the resync holds P_CH, and target[3] becomes 127.
- SLEW_STEP=255 rerun of FF 02 28: channel 2 width jumps to 960 on the first frame boundary after cmd_valid. Assert rst mid-byte: outputs go to 0 immediately and restart at width 612.
